window_sum_9x9: RTL and testbench

Downstream consumer of the 9-row line-buffer stack. Takes the nine vertically aligned row taps per pixel, forms a column sum, and slides it horizontally to produce the full 9x9 neighbourhood sum (box filter numerator) per pixel. Tracks column/row position so only windows lying entirely inside the frame are flagged valid. Propagates the frame-done marker with matching latency.

---
 rtl/window_sum_9x9_if.sv | 30 +++
 rtl/window_sum_9x9.sv | 124 ++++++++++++
 tb/tb_window_sum_9x9.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/window_sum_9x9_if.sv
// Pixel-column tap bus between the 9-row line-buffer stack (master) and the
// 9x9 window summer (slave), including the window-sum results.
interface window_sum_9x9_if;
    logic        valid_i;
    logic [7:0]  data0_i;
    logic [7:0]  data1_i;
    logic [7:0]  data2_i;
    logic [7:0]  data3_i;
    logic [7:0]  data4_i;
    logic [7:0]  data5_i;
    logic [7:0]  data6_i;
    logic [7:0]  data7_i;
    logic [7:0]  data8_i;
    logic        done_i;
    logic [14:0] sum_o;
    logic        valid_o;
    logic        done_o;

    modport master (
        output valid_i, data0_i, data1_i, data2_i, data3_i, data4_i,
               data5_i, data6_i, data7_i, data8_i, done_i,
        input  sum_o, valid_o, done_o
    );

    modport slave (
        input  valid_i, data0_i, data1_i, data2_i, data3_i, data4_i,
               data5_i, data6_i, data7_i, data8_i, done_i,
        output sum_o, valid_o, done_o
    );
endinterface

// File: rtl/window_sum_9x9.sv
// 9x9 box-filter numerator: vertical column sum of nine row taps, then a
// horizontal 9-deep sliding sum; valid only for windows fully inside the frame.
module window_sum_9x9 #(
    parameter int WIDTH  = 17,
    parameter int HEIGHT = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    window_sum_9x9_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [11:0]   r_col_sum;
    logic          r_s1_valid;
    logic          r_s1_flag;
    logic [11:0]   r_sr [9];
    logic [14:0]   r_sum;
    logic [14:0]   r_sum_o;
    logic          r_valid_o;
    logic          r_done1;
    logic          r_done_o;

    logic [11:0]   w_col_sum;
    logic          w_flag;
    logic          w_col_last;
    logic          w_row_last;
    logic [15:0]   w_sum_next;

    function automatic logic [11:0] col_sum9(
        input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
        input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
        input logic [7:0] a6, input logic [7:0] a7, input logic [7:0] a8
    );
        col_sum9 = {4'd0, a0} + {4'd0, a1} + {4'd0, a2} + {4'd0, a3}
                 + {4'd0, a4} + {4'd0, a5} + {4'd0, a6} + {4'd0, a7}
                 + {4'd0, a8};
    endfunction

    // Column sum, position flags and the next running sum.
    always_comb begin
        w_col_sum  = col_sum9(bus.data0_i, bus.data1_i, bus.data2_i,
                              bus.data3_i, bus.data4_i, bus.data5_i,
                              bus.data6_i, bus.data7_i, bus.data8_i);
        w_flag     = (r_col >= CW'(8)) && (r_row >= RW'(8));
        w_col_last = (r_col == CW'(WIDTH - 1));
        w_row_last = (r_row == RW'(HEIGHT - 1));
        // Running sum always contains the entry leaving, so this never underflows.
        w_sum_next = {1'b0, r_sum} + {4'd0, r_col_sum} - {4'd0, r_sr[8]};
    end

    // Pixel position counters; done_i restarts the frame after this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.done_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.valid_i) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? RW'(0) : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Stage 1: column sum with its in-frame flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_sum  <= 12'd0;
            r_s1_valid <= 1'b0;
            r_s1_flag  <= 1'b0;
        end else begin
            r_s1_valid <= bus.valid_i;
            if (bus.valid_i) begin
                r_col_sum <= w_col_sum;
                r_s1_flag <= w_flag;
            end
        end
    end

    // Stage 2: column-sum history and running window sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) r_sr[i] <= 12'd0;
            r_sum <= 15'd0;
        end else if (r_s1_valid) begin
            r_sr[0] <= r_col_sum;
            for (int i = 1; i < 9; i++) r_sr[i] <= r_sr[i-1];
            r_sum <= w_sum_next[14:0];
        end
    end

    // Output register; sum_o holds between in-frame windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_o   <= 15'd0;
            r_valid_o <= 1'b0;
        end else begin
            r_valid_o <= r_s1_valid && r_s1_flag;
            if (r_s1_valid && r_s1_flag) r_sum_o <= w_sum_next[14:0];
        end
    end

    // Frame-done marker delayed to match the two-stage pixel path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done1  <= 1'b0;
            r_done_o <= 1'b0;
        end else begin
            r_done1  <= bus.done_i;
            r_done_o <= r_done1;
        end
    end

    assign bus.sum_o   = r_sum_o;
    assign bus.valid_o = r_valid_o;
    assign bus.done_o  = r_done_o;
endmodule

// File: tb/tb_window_sum_9x9.sv
// Directed bench for window_sum_9x9 with WIDTH=17, HEIGHT=12 (36 windows/frame).
module tb_window_sum_9x9;
    localparam int W = 17;
    localparam int H = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    window_sum_9x9_if bus();

    window_sum_9x9 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   failures = 0;
    int   col = 0;
    int   row = 0;
    int   tap_k = 0;
    int   vcount = 0;
    int   last_sum = 0;
    int   pend_s = 0;
    logic pend_v = 1'b0;
    logic pend_d = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_taps(input int mode);
        logic [7:0] t [9];
        for (int j = 0; j < 9; j++) begin
            case (mode)
                0:       t[j] = 8'(tap_k);
                1:       t[j] = 8'(j + 1);
                default: t[j] = 8'(col);
            endcase
        end
        bus.data0_i = t[0]; bus.data1_i = t[1]; bus.data2_i = t[2];
        bus.data3_i = t[3]; bus.data4_i = t[4]; bus.data5_i = t[5];
        bus.data6_i = t[6]; bus.data7_i = t[7]; bus.data8_i = t[8];
    endtask

    // One clock: drive a pixel (mode 0 const tap_k, 1 taps 1..9, 2 ramp),
    // then check the outputs for the pixel driven one step earlier.
    task automatic step(input logic v, input int mode, input logic d);
        logic cflag;
        int   cs;
        @(negedge clk);
        bus.valid_i = v;
        bus.done_i  = d;
        set_taps(mode);
        cflag = v && (col >= 8) && (row >= 8);
        cs = (mode == 0) ? 81 * tap_k : (mode == 1) ? 405 : 81 * col - 324;
        if (v) begin
            if (col == W - 1) begin
                col = 0;
                row = (row == H - 1) ? 0 : row + 1;
            end else begin
                col = col + 1;
            end
        end
        if (d) begin
            col = 0;
            row = 0;
        end
        @(posedge clk);
        #1;
        chk("valid_o", {31'd0, bus.valid_o}, {31'd0, pend_v});
        chk("done_o", {31'd0, bus.done_o}, {31'd0, pend_d});
        if (pend_v) begin
            chk("sum_o", {17'd0, bus.sum_o}, 32'(pend_s));
            last_sum = pend_s;
        end else begin
            chk("sum_hold", {17'd0, bus.sum_o}, 32'(last_sum));
        end
        if (bus.valid_o === 1'b1) vcount++;
        pend_v = cflag;
        pend_s = cs;
        pend_d = d;
    endtask

    task automatic model_reset();
        col = 0; row = 0; pend_v = 1'b0; pend_d = 1'b0; pend_s = 0; last_sum = 0;
    endtask

    initial begin
        int accepted;
        logic v;
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        bus.done_i  = 1'b0;
        set_taps(0);
        #1;
        chk("reset_sum", {17'd0, bus.sum_o}, 32'd0);
        chk("reset_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("reset_done", {31'd0, bus.done_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // All taps 1, continuous frame.
        tap_k = 1; vcount = 0;
        repeat (W * H) step(1'b1, 0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0);
        chk("t1_count", 32'(vcount), 32'd36);

        // All taps 255, continuous frame: max sum.
        tap_k = 255; vcount = 0;
        repeat (W * H) step(1'b1, 0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0);
        chk("t2_count", 32'(vcount), 32'd36);

        // Taps 1..9 with random gaps.
        vcount = 0; accepted = 0;
        while (accepted < W * H) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, 1, 1'b0);
            if (v) accepted++;
        end
        repeat (2) step(1'b0, 1, 1'b0);
        chk("t3_count", 32'(vcount), 32'd36);

        // Horizontal ramp.
        vcount = 0;
        repeat (W * H) step(1'b1, 2, 1'b0);
        repeat (2) step(1'b0, 2, 1'b0);
        chk("t4_count", 32'(vcount), 32'd36);

        // Mid-frame done at (5,9), then a full restarted frame.
        tap_k = 1;
        repeat (9 * W + 5) step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b1);
        vcount = 0;
        repeat (W * H) step(1'b1, 0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0);
        chk("t5_count", 32'(vcount), 32'd36);
        repeat (3) step(1'b0, 0, 1'b1);
        repeat (2) step(1'b0, 0, 1'b0);

        // Asynchronous reset mid-row during a ramp.
        repeat (9 * W + 12) step(1'b1, 2, 1'b0);
        chk("pre_reset_valid", {31'd0, bus.valid_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        chk("async_sum", {17'd0, bus.sum_o}, 32'd0);
        chk("async_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("async_done", {31'd0, bus.done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tap_k = 2; vcount = 0;
        repeat (W * H) step(1'b1, 0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0);
        chk("t6_count", 32'(vcount), 32'd36);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
